// File: rtl/core_muldiv_seq_pkg.sv
// Shared execute-stage definitions for the iterative multiply/divide sequencer.
package i2d_core_defines;

   typedef enum logic [2:0] {
      IDLE,
      PREP,
      CALC,
      FIX,
      DONE
   } muldiv_state_t;

   localparam int unsigned MULDIV_ITER        = 32;
   localparam logic [31:0] MULDIV_DIV0_RESULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/core_muldiv_seq_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide
// over a {high, low} accumulator pair.
module core_muldiv_step
   import i2d_core_defines::*;
#(
   parameter int unsigned XLEN = MULDIV_ITER
) (
   input  logic              op_div,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   always_comb begin
      sum    = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
      // remainder shifted left with the next dividend bit pulled in from the low half
      rem_sh = acc_i[2*XLEN-1:XLEN-1];
      diff   = rem_sh - {1'b0, opnd_i};
      if (!op_div) begin
         acc_o = {sum, acc_i[XLEN-1:1]};
      end else if (!diff[XLEN]) begin
         acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end else begin
         acc_o = {rem_sh[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/core_muldiv_seq.sv
// Iterative MUL/DIV sequencer: sign handling, XLEN-step iteration and
// registered result/flags with a start/busy/done handshake.
module core_muldiv_seq
   import i2d_core_defines::*;
#(
   parameter int unsigned XLEN = MULDIV_ITER
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            op_div,
   input  logic            is_signed,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic            flush,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic            sr_zf,
   output logic            div_by_zero
);

   localparam int unsigned CW = $clog2(XLEN);

   muldiv_state_t     state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   logic              op_div_q, op_div_d;
   logic              signed_q, signed_d;
   logic              neg_q, neg_d;
   logic [XLEN-1:0]   result_q, result_d;
   logic              zf_q, zf_d;
   logic              dbz_q, dbz_d;

   logic [2*XLEN-1:0] step_acc;
   logic              accept;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs, quo, res_fix;

   core_muldiv_step #(.XLEN(XLEN)) u_step (
      .op_div (op_div_q),
      .acc_i  (acc_q),
      .opnd_i (opnd_q),
      .acc_o  (step_acc)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      op_div_d = op_div_q;
      signed_d = signed_q;
      neg_d    = neg_q;
      result_d = result_q;
      zf_d     = zf_q;
      dbz_d    = dbz_q;

      accept = start && !flush && (state_q == IDLE || state_q == DONE);

      // raw operands sit in acc low half (a) and opnd (b) until PREP
      a_neg = signed_q && acc_q[XLEN-1];
      b_neg = signed_q && opnd_q[XLEN-1];
      a_abs = a_neg ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      b_abs = b_neg ? -opnd_q : opnd_q;

      quo     = acc_q[XLEN-1:0];
      res_fix = neg_q ? -quo : quo;
      if (op_div_q && opnd_q == '0) begin
         res_fix = '1;
      end

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (accept) begin
               state_d  = PREP;
               acc_d    = {{XLEN{1'b0}}, operand_a};
               opnd_d   = operand_b;
               op_div_d = op_div;
               signed_d = is_signed;
            end
         end
         PREP: begin
            state_d = CALC;
            cnt_d   = CW'(XLEN - 1);
            neg_d   = a_neg ^ b_neg;
            if (op_div_q) begin
               acc_d  = {{XLEN{1'b0}}, a_abs};
               opnd_d = b_abs;
            end else begin
               acc_d  = {{XLEN{1'b0}}, b_abs};
               opnd_d = a_abs;
            end
         end
         CALC: begin
            acc_d = step_acc;
            if (cnt_q == '0) begin
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FIX: begin
            state_d  = DONE;
            result_d = res_fix;
            zf_d     = ~|res_fix;
            dbz_d    = op_div_q && (opnd_q == '0);
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
         zf_d     = zf_q;
         dbz_d    = dbz_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         op_div_q <= 1'b0;
         signed_q <= 1'b0;
         neg_q    <= 1'b0;
         result_q <= '0;
         zf_q     <= 1'b0;
         dbz_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         op_div_q <= op_div_d;
         signed_q <= signed_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         zf_q     <= zf_d;
         dbz_q    <= dbz_d;
      end
   end

   assign busy        = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
   assign done        = (state_q == DONE);
   assign result      = result_q;
   assign sr_zf       = zf_q;
   assign div_by_zero = dbz_q;

endmodule

// File: doc/core_muldiv_seq.md
# core_muldiv_seq

Iterative multiply/divide sequencer for the execute stage. It takes MUL/DIV operations off the single-cycle ALU path and runs them as radix-2 shift-add (multiply) or restoring shift-subtract (divide) over 32 iterations. A start/busy/done handshake lets the pipeline controller stall issue until the result is ready. The result and zero flag feed the same writeback and SR update path as the ALU.

## Interface
Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op_div  in  1  0 = multiply, 1 = divide.
- is_signed  in  1  signed operation (instr `s` bit).
- operand_a  in  XLEN  multiplicand / dividend; captured on accepted start.
- operand_b  in  XLEN  multiplier / divisor; captured on accepted start.
- flush  in  1  synchronous abort from the pipeline.
- busy  out  1  high in PREP, CALC and FIX.
- done  out  1  one-cycle pulse in DONE; result valid.
- result  out  XLEN  low XLEN bits of product, or quotient.
- sr_zf  out  1  ~|result, valid with done and held.
- div_by_zero  out  1  divide with operand_b==0, valid with done and held.

## Operation
- States:
  - IDLE: wait for start.
  - PREP: take absolute values when is_signed; record the result sign as a_sign^b_sign for divide, the same for multiply.
  - CALC: XLEN iterations, counter XLEN-1 down to 0.
  - FIX: conditional two's-complement negate, div-by-zero override.
  - DONE: pulse done.
- Transitions:
  - IDLE→PREP on start.
  - PREP→CALC unconditionally.
  - CALC→FIX when the counter reaches 0.
  - FIX→DONE.
  - DONE→PREP on start, otherwise DONE→IDLE.
- Multiply: 2·XLEN-bit accumulator, add the multiplicand when the multiplier LSB is 1, then shift right. Only the low XLEN bits go to result. For the low bits, signed and unsigned give identical values.
- Divide: remainder/quotient register pair. Each step: shift left, trial-subtract the divisor, keep the subtraction if it does not borrow, and set the quotient bit. The quotient truncates toward zero; the remainder is discarded.
- Divide by zero: result forced to all-ones and div_by_zero=1, for both signed and unsigned.
- Signed 0x80000000 / 0xFFFFFFFF gives result 0x80000000 and div_by_zero=0. No trap.
- start while busy is ignored; operands are not recaptured.
- flush in any state forces IDLE next cycle with no done. result, sr_zf and div_by_zero keep their previous values.
- flush and start in the same cycle: flush wins and start is dropped.
- rst, including mid-operation: state IDLE, counter 0; busy, done, result, sr_zf and div_by_zero all 0. Note sr_zf is 0 at reset even though result is 0.

## Timing
- start accepted at the edge ending cycle N:
  - PREP in N+1.
  - CALC in N+2…N+33.
  - FIX in N+34.
  - DONE in N+35.
  - Latency is XLEN+3 cycles from acceptance to the done pulse.
- busy is high in N+1…N+34 and low in DONE. A start in the DONE cycle is accepted, so back-to-back operations issue every XLEN+3 cycles.
- result, sr_zf and div_by_zero are registered. They update on entry to DONE and hold until the next DONE or rst.
- No combinational path from any input to any output.

## Structure
- Add to i2d_core_defines package:
  - muldiv_state_t enum {IDLE, PREP, CALC, FIX, DONE}.
  - MULDIV_ITER = 32.
  - MULDIV_DIV0_RESULT = 32'hFFFF_FFFF.
- Sub-module core_muldiv_step: one combinational iteration (add-shift or subtract-shift selected by op_div). It is instantiated once and its output is registered each CALC cycle.
- The FSM, counter, sign flags and negate logic live in core_muldiv_seq.

## Test plan
- Unsigned mul 0x0001_0003 × 0x0000_0005 → result 0x0005_000F, done exactly 35 cycles after start, sr_zf=0.
- Signed div −7 / 2 → result 0xFFFF_FFFD (−3). Signed 0x8000_0000 / 0xFFFF_FFFF → result 0x8000_0000, div_by_zero=0.
- Divide 0x1234 / 0 (signed and unsigned) → result 0xFFFF_FFFF, div_by_zero=1. Unsigned 0 / 5 → result 0, sr_zf=1.
- start pulsed during CALC with new operands → ignored; the original result is delivered. start in the DONE cycle → second done 35 cycles later.
- flush at CALC cycle 10 → busy low next cycle, no done, result unchanged. flush and start together in IDLE → stays IDLE.
- rst asserted asynchronously mid-CALC → all outputs 0 immediately. After release, a fresh mul 3×4 → result 12.
